// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: FSM states and the hold/jump
// control levels used on the interface to pc_reg, if_id and id_ex.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CtrlRun     = 2'b00,
    CtrlFlush   = 2'b01,
    CtrlDivWait = 2'b10
  } ctrl_state_e;

  localparam logic        HoldEnable  = 1'b1;
  localparam logic        HoldDisable = 1'b0;
  localparam logic        JumpEnable  = 1'b1;
  localparam logic        JumpDisable = 1'b0;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter: increments while enabled and sticks at all-ones.
module pipe_ctrl_sat_cnt #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: arbitrates jump, divider, bus-hold and load-use hazards into
// per-stage hold/stall/flush commands and counts stalled cycles.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned DIV_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        div_start_i,
  input  logic        div_done_i,
  input  logic        bus_hold_i,
  input  logic        load_use_i,
  output logic        hold_pc_o,
  output logic        stall_if_id_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        div_timeout_o,
  output logic [31:0] stall_cnt_o
);

  import pipe_ctrl_pkg::*;

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] DivLast   = 8'(DIV_TIMEOUT - 1);

  ctrl_state_e state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        div_timeout_q, div_timeout_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= CtrlRun;
      flush_cnt_q   <= '0;
      div_cnt_q     <= '0;
      div_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      div_cnt_q     <= div_cnt_d;
      div_timeout_q <= div_timeout_q | div_timeout_set;
    end
  end

  // Outputs are evaluated only out of reset; under reset everything stays at its default.
  always_comb begin
    state_d         = state_q;
    flush_cnt_d     = flush_cnt_q;
    div_cnt_d       = div_cnt_q;
    div_timeout_set = 1'b0;
    hold_pc_o       = HoldDisable;
    stall_if_id_o   = HoldDisable;
    flush_if_id_o   = HoldDisable;
    flush_id_ex_o   = HoldDisable;
    jump_flag_o     = JumpDisable;
    jump_addr_o     = ZeroWord;

    if (rst) begin
      if (jump_flag_i) begin
        jump_flag_o   = JumpEnable;
        jump_addr_o   = jump_addr_i;
        flush_if_id_o = HoldEnable;
        flush_id_ex_o = HoldEnable;
        div_cnt_d     = '0;
        if (FLUSH_CYCLES > 1) begin
          state_d     = CtrlFlush;
          flush_cnt_d = FlushLoad;
        end else begin
          state_d     = CtrlRun;
          flush_cnt_d = '0;
        end
      end else begin
        case (state_q)
          CtrlFlush: begin
            flush_if_id_o = HoldEnable;
            flush_id_ex_o = HoldEnable;
            if (flush_cnt_q <= 3'd1) begin
              state_d     = CtrlRun;
              flush_cnt_d = '0;
            end else begin
              flush_cnt_d = flush_cnt_q - 3'd1;
            end
          end
          CtrlDivWait: begin
            hold_pc_o     = HoldEnable;
            stall_if_id_o = HoldEnable;
            flush_id_ex_o = HoldEnable;
            div_cnt_d     = div_cnt_q + 8'd1;
            // Done beats a simultaneous timeout.
            if (div_done_i) begin
              state_d   = CtrlRun;
              div_cnt_d = '0;
            end else if (div_cnt_q >= DivLast) begin
              state_d         = CtrlRun;
              div_cnt_d       = '0;
              div_timeout_set = 1'b1;
            end
          end
          default: begin
            if (div_start_i) begin
              hold_pc_o     = HoldEnable;
              stall_if_id_o = HoldEnable;
              flush_id_ex_o = HoldEnable;
              state_d       = CtrlDivWait;
              div_cnt_d     = '0;
            end else if (bus_hold_i || load_use_i) begin
              hold_pc_o     = HoldEnable;
              stall_if_id_o = HoldEnable;
              flush_id_ex_o = HoldEnable;
            end
          end
        endcase
      end
    end
  end

  assign div_timeout_o = div_timeout_q;

  pipe_ctrl_sat_cnt #(
    .Width(32)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .en_i (hold_pc_o),
    .cnt_o(stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int unsigned FlushCycles = 3;
  localparam int unsigned DivTimeout  = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        div_start_i = 1'b0;
  logic        div_done_i = 1'b0;
  logic        bus_hold_i = 1'b0;
  logic        load_use_i = 1'b0;
  logic        hold_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o, jump_flag_o;
  logic [31:0] jump_addr_o, stall_cnt_o;
  logic        div_timeout_o;

  pipe_ctrl #(
    .FLUSH_CYCLES(FlushCycles),
    .DIV_TIMEOUT (DivTimeout)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .div_start_i  (div_start_i),
    .div_done_i   (div_done_i),
    .bus_hold_i   (bus_hold_i),
    .load_use_i   (load_use_i),
    .hold_pc_o    (hold_pc_o),
    .stall_if_id_o(stall_if_id_o),
    .flush_if_id_o(flush_if_id_o),
    .flush_id_ex_o(flush_id_ex_o),
    .jump_flag_o  (jump_flag_o),
    .jump_addr_o  (jump_addr_o),
    .div_timeout_o(div_timeout_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [69:0] act_vec;
  assign act_vec = {hold_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o, jump_flag_o,
                    jump_addr_o, div_timeout_o, stall_cnt_o};

  // Behavioural model: remaining bubble cycles, divide in flight and its age.
  int          m_flush_left = 0;
  bit          m_in_div = 1'b0;
  int          m_div_age = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_stalls = '0;
  logic        e_hold, e_stall, e_fi, e_fe, e_jf;
  logic [31:0] e_addr;
  logic [69:0] exp_vec;

  function automatic void model_eval();
    {e_hold, e_stall, e_fi, e_fe, e_jf} = '0;
    e_addr = '0;
    if (rst) begin
      if (jump_flag_i) begin
        e_jf = 1'b1; e_addr = jump_addr_i; e_fi = 1'b1; e_fe = 1'b1;
      end else if (m_flush_left > 0) begin
        e_fi = 1'b1; e_fe = 1'b1;
      end else if (m_in_div || div_start_i || bus_hold_i || load_use_i) begin
        e_hold = 1'b1; e_stall = 1'b1; e_fe = 1'b1;
      end
    end
    exp_vec = {e_hold, e_stall, e_fi, e_fe, e_jf, e_addr, m_err, m_stalls};
  endfunction

  function automatic void model_tick();
    if (!rst) begin
      m_flush_left = 0; m_in_div = 1'b0; m_div_age = 0; m_err = 1'b0; m_stalls = '0;
      return;
    end
    if (e_hold && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
    if (jump_flag_i) begin
      m_flush_left = int'(FlushCycles) - 1;
      m_in_div = 1'b0;
      m_div_age = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (m_in_div) begin
      if (div_done_i) begin
        m_in_div = 1'b0;
      end else if (m_div_age + 1 == int'(DivTimeout)) begin
        m_in_div = 1'b0;
        m_err = 1'b1;
      end else begin
        m_div_age++;
      end
    end else if (div_start_i) begin
      m_in_div = 1'b1;
      m_div_age = 0;
    end
  endfunction

  task automatic apply(input logic jf, input logic [31:0] ja, input logic ds, input logic dd,
                       input logic bh, input logic lu);
    @(negedge clk);
    jump_flag_i = jf; jump_addr_i = ja; div_start_i = ds;
    div_done_i = dd; bus_hold_i = bh; load_use_i = lu;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (act_vec !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: got %h expected 0", act_vec);
      end
      tick();
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_eval();
    n_cmp++;
    if ({jump_flag_o, flush_id_ex_o, flush_if_id_o, hold_pc_o, jump_addr_o} !==
        {1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100}) begin
      n_err++;
      $display("FAIL reset_release_jump: got jf=%b fe=%b fi=%b hold=%b addr=%h", jump_flag_o,
               flush_id_ex_o, flush_if_id_o, hold_pc_o, jump_addr_o);
    end
    tick();
    idle(4);
  endtask

  task automatic test_jump_flush();
    int n_jf = 0, n_fi = 0, n_fe = 0, n_hold = 0;
    for (int i = 0; i < 6; i++) begin
      apply(i == 0, (i == 0) ? 32'h0000_0100 : 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL jump_flush_cycle%0d: got %h expected %h", i, act_vec, exp_vec);
      end
      if (jump_flag_o && jump_addr_o == 32'h0000_0100) n_jf++;
      n_fi += int'(flush_if_id_o);
      n_fe += int'(flush_id_ex_o);
      n_hold += int'(hold_pc_o);
      tick();
    end
    n_cmp++;
    if (n_jf != 1 || n_fi != 3 || n_fe != 3 || n_hold != 0) begin
      n_err++;
      $display("FAIL jump_flush_counts: got jf=%0d fi=%0d fe=%0d hold=%0d expected 1 3 3 0",
               n_jf, n_fi, n_fe, n_hold);
    end
  endtask

  task automatic test_divide();
    int n_hold = 0;
    logic [31:0] c0 = stall_cnt_o;
    for (int i = 0; i < 12; i++) begin
      apply(1'b0, '0, i == 0, i == 10, 1'b0, 1'b0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL divide_cycle%0d: got %h expected %h", i, act_vec, exp_vec);
      end
      if (hold_pc_o && stall_if_id_o && flush_id_ex_o) n_hold++;
      tick();
    end
    n_cmp++;
    if (n_hold != 11 || stall_cnt_o - c0 != 32'd11) begin
      n_err++;
      $display("FAIL divide_len: got hold=%0d stall_delta=%0d expected 11 11", n_hold,
               stall_cnt_o - c0);
    end
  endtask

  task automatic test_timeout();
    int n_hold = 0;
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, '0, i == 0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL timeout_cycle%0d: got %h expected %h", i, act_vec, exp_vec);
      end
      n_hold += int'(hold_pc_o);
      tick();
    end
    n_cmp++;
    if (n_hold != int'(DivTimeout) + 1 || div_timeout_o !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_release: got hold=%0d err=%b expected %0d 1", n_hold,
               div_timeout_o, DivTimeout + 1);
    end
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, '0, i == 0, i == 4, 1'b0, 1'b0);
      tick();
    end
    apply(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (div_timeout_o !== 1'b1 || hold_pc_o !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_sticky: got err=%b hold=%b expected 1 0", div_timeout_o,
               hold_pc_o);
    end
    tick();
  endtask

  task automatic test_jump_in_div();
    logic [31:0] addr = $urandom();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, '0, i == 0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    apply(1'b1, addr, 1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if ({jump_flag_o, jump_addr_o, flush_if_id_o, flush_id_ex_o, hold_pc_o, stall_if_id_o} !==
        {1'b1, addr, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL jump_in_div: got jf=%b addr=%h fi=%b fe=%b hold=%b stall=%b", jump_flag_o,
               jump_addr_o, flush_if_id_o, flush_id_ex_o, hold_pc_o, stall_if_id_o);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL jump_in_div_after%0d: got %h expected %h", i, act_vec, exp_vec);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [31:0] c0;
    apply(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    apply(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({hold_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o} !== 4'b0011) begin
      n_err++;
      $display("FAIL load_use_in_flush: got %b expected 0011",
               {hold_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o});
    end
    tick();
    idle(3);
    apply(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    c0 = stall_cnt_o;
    n_cmp++;
    if ({hold_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o} !== 4'b1101) begin
      n_err++;
      $display("FAIL load_use_in_run: got %b expected 1101",
               {hold_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o});
    end
    tick();
    apply(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (hold_pc_o !== 1'b0 || stall_cnt_o !== c0 + 32'd1) begin
      n_err++;
      $display("FAIL load_use_count: got hold=%b cnt=%0d expected 0 %0d", hold_pc_o,
               stall_cnt_o, c0 + 32'd1);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(11) == 0, $urandom(), $urandom_range(7) == 0,
            $urandom_range(9) == 0, $urandom_range(5) == 0, $urandom_range(4) == 0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, act_vec, exp_vec);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_jump_flush();
    test_divide();
    test_timeout();
    test_jump_in_div();
    test_load_use();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
